// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache request widths and opcode encodings
package cache_pkg;
  localparam int CL_SIZE = 128;
  localparam int ADDR_W  = 32;
  localparam int OP_W    = 3;
  localparam int ID_W    = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_EVICT = 3'd3,
    OP_SNOOP = 3'd4,
    OP_FLUSH = 3'd5
  } cache_op_e;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - one-hot round-robin pick starting at a pointer, with wrap-around
module rr_pick #(
  parameter int  WIDTH = 6,
  localparam int PW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [WIDTH-1:0] o_grant
);
  logic [2*WIDTH-1:0] w_dbl;
  logic [2*WIDTH-1:0] w_first;
  logic               w_hit;

  // Scanning the doubled vector from the pointer covers the wrap in one pass.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_first = '0;
    w_hit   = 1'b0;
    for (int j = 0; j < 2*WIDTH; j++) begin
      if (!w_hit && w_dbl[j] && (j >= int'(i_ptr))) begin
        w_first[j] = 1'b1;
        w_hit      = 1'b1;
      end
    end
  end

  assign o_grant = w_first[WIDTH-1:0] | w_first[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/queue_arbiter_rr.sv
// rtl/queue_arbiter_rr.sv - registered round-robin arbiter over cache request queues
module queue_arbiter_rr
  import cache_pkg::*;
#(
  parameter int  CL_SIZE    = cache_pkg::CL_SIZE,
  parameter int  Q_WIDTH    = 6,
  parameter bit  FLUSH_PRIO = 1'b1,
  localparam int IDX_W      = $clog2(Q_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W*Q_WIDTH-1:0]  addr_in,
  input  logic [CL_SIZE*Q_WIDTH-1:0] data_in,
  input  logic [OP_W*Q_WIDTH-1:0]    operation_in,
  input  logic [Q_WIDTH-1:0]         valid_in,
  input  logic [ID_W*Q_WIDTH-1:0]    src_in,
  input  logic [ID_W*Q_WIDTH-1:0]    dest_in,
  input  logic [Q_WIDTH-1:0]         is_flush_in,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic [ADDR_W-1:0]          addr_out,
  output logic [CL_SIZE-1:0]         data_out,
  output logic [OP_W-1:0]            operation_out,
  output logic [ID_W-1:0]            src_out,
  output logic [ID_W-1:0]            dest_out,
  output logic                       is_flush_out,
  output logic [IDX_W-1:0]           grant_idx_out,
  output logic [Q_WIDTH-1:0]         dealloc
);
  logic               w_load;
  logic [Q_WIDTH-1:0] w_flush_req;
  logic [Q_WIDTH-1:0] w_grant_flush;
  logic [Q_WIDTH-1:0] w_grant_all;
  logic [Q_WIDTH-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_next_ptr;
  logic [ADDR_W-1:0]  w_addr;
  logic [CL_SIZE-1:0] w_data;
  logic [OP_W-1:0]    w_op;
  logic [ID_W-1:0]    w_src;
  logic [ID_W-1:0]    w_dest;
  logic               w_flush;

  logic               r_valid;
  logic [ADDR_W-1:0]  r_addr;
  logic [CL_SIZE-1:0] r_data;
  logic [OP_W-1:0]    r_op;
  logic [ID_W-1:0]    r_src;
  logic [ID_W-1:0]    r_dest;
  logic               r_flush;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;

  assign w_load      = ~r_valid | ready_in;
  assign w_flush_req = valid_in & is_flush_in;

  rr_pick #(.WIDTH(Q_WIDTH)) u_pick_flush (
    .i_req   (w_flush_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_flush)
  );

  rr_pick #(.WIDTH(Q_WIDTH)) u_pick_all (
    .i_req   (valid_in),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_all)
  );

  assign w_grant = (FLUSH_PRIO && (|w_flush_req)) ? w_grant_flush : w_grant_all;

  // Grant is one-hot, so an OR-mux selects the winner's fields and index.
  always_comb begin
    w_idx   = '0;
    w_addr  = '0;
    w_data  = '0;
    w_op    = '0;
    w_src   = '0;
    w_dest  = '0;
    w_flush = 1'b0;
    for (int i = 0; i < Q_WIDTH; i++) begin
      if (w_grant[i]) begin
        w_idx   = w_idx   | IDX_W'(i);
        w_addr  = w_addr  | addr_in[ADDR_W*i +: ADDR_W];
        w_data  = w_data  | data_in[CL_SIZE*i +: CL_SIZE];
        w_op    = w_op    | operation_in[OP_W*i +: OP_W];
        w_src   = w_src   | src_in[ID_W*i +: ID_W];
        w_dest  = w_dest  | dest_in[ID_W*i +: ID_W];
        w_flush = w_flush | is_flush_in[i];
      end
    end
  end

  assign w_next_ptr = (w_idx == IDX_W'(Q_WIDTH-1)) ? '0 : w_idx + IDX_W'(1);
  assign dealloc    = (w_load && !rst) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_op    <= OP_NOP;
      r_src   <= '0;
      r_dest  <= '0;
      r_flush <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (|w_grant) begin
        r_valid <= 1'b1;
        r_addr  <= w_addr;
        r_data  <= w_data;
        r_op    <= w_op;
        r_src   <= w_src;
        r_dest  <= w_dest;
        r_flush <= w_flush;
        r_idx   <= w_idx;
        r_ptr   <= w_next_ptr;
      end else begin
        r_valid <= 1'b0;
        r_addr  <= '0;
        r_data  <= '0;
        r_op    <= OP_NOP;
        r_src   <= '0;
        r_dest  <= '0;
        r_flush <= 1'b0;
        r_idx   <= '0;
      end
    end
  end

  assign valid_out     = r_valid;
  assign addr_out      = r_addr;
  assign data_out      = r_data;
  assign operation_out = r_op;
  assign src_out       = r_src;
  assign dest_out      = r_dest;
  assign is_flush_out  = r_flush;
  assign grant_idx_out = r_idx;
endmodule

// File: tb/tb_queue_arbiter_rr.sv
// tb/tb_queue_arbiter_rr.sv - randomized bench for queue_arbiter_rr against a queue-scan model
module tb_queue_arbiter_rr;
  localparam int Q  = 6;
  localparam int CL = 128;

  logic            clk;
  logic            rst;
  logic [32*Q-1:0] addr_in;
  logic [CL*Q-1:0] data_in;
  logic [3*Q-1:0]  operation_in;
  logic [Q-1:0]    valid_in;
  logic [2*Q-1:0]  src_in;
  logic [2*Q-1:0]  dest_in;
  logic [Q-1:0]    is_flush_in;
  logic            ready_in;

  logic          vo  [2];
  logic [31:0]   ao  [2];
  logic [CL-1:0] dto [2];
  logic [2:0]    oo  [2];
  logic [1:0]    so  [2];
  logic [1:0]    deo [2];
  logic          fo  [2];
  logic [2:0]    gio [2];
  logic [Q-1:0]  dlo [2];

  int total = 0;
  int bad   = 0;

  // model state: index 0 has flush priority, index 1 is pure round-robin
  int          m_ptr [2];
  bit          m_v   [2];
  logic [31:0] m_a   [2];
  logic [CL-1:0] m_d [2];
  logic [2:0]  m_op  [2];
  logic [1:0]  m_s   [2];
  logic [1:0]  m_de  [2];
  logic        m_f   [2];
  int          m_idx [2];

  queue_arbiter_rr #(.CL_SIZE(CL), .Q_WIDTH(Q), .FLUSH_PRIO(1'b1)) u_dut_fp (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .operation_in(operation_in), .valid_in(valid_in), .src_in(src_in),
    .dest_in(dest_in), .is_flush_in(is_flush_in), .ready_in(ready_in),
    .valid_out(vo[0]), .addr_out(ao[0]), .data_out(dto[0]), .operation_out(oo[0]),
    .src_out(so[0]), .dest_out(deo[0]), .is_flush_out(fo[0]),
    .grant_idx_out(gio[0]), .dealloc(dlo[0])
  );

  queue_arbiter_rr #(.CL_SIZE(CL), .Q_WIDTH(Q), .FLUSH_PRIO(1'b0)) u_dut_rr (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .operation_in(operation_in), .valid_in(valid_in), .src_in(src_in),
    .dest_in(dest_in), .is_flush_in(is_flush_in), .ready_in(ready_in),
    .valid_out(vo[1]), .addr_out(ao[1]), .data_out(dto[1]), .operation_out(oo[1]),
    .src_out(so[1]), .dest_out(deo[1]), .is_flush_out(fo[1]),
    .grant_idx_out(gio[1]), .dealloc(dlo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int ptr, input logic [Q-1:0] v, input logic [Q-1:0] f, input bit fp);
    logic [Q-1:0] e;
    e = v;
    if (fp && ((v & f) != '0)) e = v & f;
    for (int k = 0; k < Q; k++)
      if (e[(ptr + k) % Q]) return (ptr + k) % Q;
    return -1;
  endfunction

  task automatic model_clear(input int m);
    m_v[m] = 1'b0; m_a[m] = '0; m_d[m] = '0; m_op[m] = '0;
    m_s[m] = '0; m_de[m] = '0; m_f[m] = 1'b0; m_idx[m] = 0;
  endtask

  task automatic rand_fields();
    for (int q = 0; q < Q; q++) begin
      addr_in[32*q +: 32]     = $urandom;
      data_in[CL*q +: CL]     = {$urandom, $urandom, $urandom, $urandom};
      operation_in[3*q +: 3]  = 3'($urandom_range(1, 5));
      src_in[2*q +: 2]        = 2'($urandom);
      dest_in[2*q +: 2]       = 2'($urandom);
    end
  endtask

  // Called just after inputs change at a falling edge; returns at the next falling edge.
  task automatic cycle();
    int g  [2];
    bit ld [2];
    #1;
    for (int m = 0; m < 2; m++) begin
      ld[m] = !m_v[m] || ready_in;
      g[m]  = pick(m_ptr[m], valid_in, is_flush_in, m == 0);
      check($sformatf("d%0d.dealloc", m), dlo[m],
            (rst || !ld[m] || g[m] < 0) ? '0 : (128'd1 << g[m]));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        model_clear(m);
        m_ptr[m] = 0;
      end else if (ld[m]) begin
        if (g[m] >= 0) begin
          m_v[m]   = 1'b1;
          m_a[m]   = addr_in[32*g[m] +: 32];
          m_d[m]   = data_in[CL*g[m] +: CL];
          m_op[m]  = operation_in[3*g[m] +: 3];
          m_s[m]   = src_in[2*g[m] +: 2];
          m_de[m]  = dest_in[2*g[m] +: 2];
          m_f[m]   = is_flush_in[g[m]];
          m_idx[m] = g[m];
          m_ptr[m] = (g[m] + 1) % Q;
        end else begin
          model_clear(m);
        end
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("d%0d.valid", m), vo[m],  m_v[m]);
      check($sformatf("d%0d.addr",  m), ao[m],  m_a[m]);
      check($sformatf("d%0d.data",  m), dto[m], m_d[m]);
      check($sformatf("d%0d.op",    m), oo[m],  m_op[m]);
      check($sformatf("d%0d.src",   m), so[m],  m_s[m]);
      check($sformatf("d%0d.dest",  m), deo[m], m_de[m]);
      check($sformatf("d%0d.flush", m), fo[m],  m_f[m]);
      if (m_v[m] || rst)
        check($sformatf("d%0d.idx", m), gio[m], 128'(m_idx[m]));
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ready_in = 1'b1; valid_in = '0; is_flush_in = '0;
    rand_fields();
    for (int m = 0; m < 2; m++) begin model_clear(m); m_ptr[m] = 0; end
    @(negedge clk);
    repeat (2) cycle();
    check("reset.valid", vo[0], 0);
    rst = 1'b0;
    repeat (5) cycle();
    check("idle.op", oo[0], 0);

    valid_in = '1;
    for (int k = 0; k < 7; k++) begin
      rand_fields();
      cycle();
      check("rr_seq", gio[0], 128'(k % Q));
    end

    rst = 1'b1; cycle(); rst = 1'b0;
    valid_in = 6'b100001; is_flush_in = 6'b100000;
    cycle();
    check("fp1_first", gio[0], 5);
    check("fp0_first", gio[1], 0);
    is_flush_in = '0;

    rst = 1'b1; cycle(); rst = 1'b0;
    valid_in = 6'b000100; addr_in[64 +: 32] = 32'h1000;
    cycle();
    check("hold.load", ao[0], 32'h1000);
    ready_in = 1'b0; valid_in = '1;
    repeat (4) begin
      rand_fields();
      cycle();
      check("hold.addr", ao[0], 32'h1000);
    end
    ready_in = 1'b1;
    cycle();
    check("hold.next", gio[0], 3);

    valid_in = 6'b001000;
    cycle();
    check("wrap.grant", gio[0], 3);
    valid_in = '1;
    cycle();
    check("wrap.ptr", gio[0], 4);

    ready_in = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check("rst.drop", vo[0], 0);
    rst = 1'b0; ready_in = 1'b1;
    cycle();
    check("rst.restart", gio[0], 0);

    repeat (400) begin
      rand_fields();
      valid_in    = Q'($urandom);
      is_flush_in = Q'($urandom);
      ready_in    = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/queue_arbiter_rr.md
# queue_arbiter_rr

Registered round-robin arbiter that selects one request per cycle from `Q_WIDTH` cache request queues (miss, eviction, snoop, flush, etc.) and forwards it to the cache pipeline through a one-entry output register with a valid/ready handshake. It replaces the combinational fixed-priority queue arbitrator with three improvements: fair rotating priority, an optional flush-first mode, and backpressure-correct dequeue. It sits between the per-source request queues and the cache tag/data pipeline.

## Interface
- `CL_SIZE`, 128: cache-line data width in bits.
- `Q_WIDTH`, 6: number of input queues (≥2).
- `FLUSH_PRIO`, 1: when 1, valid flush requests win over non-flush requests; when 0, pure round-robin.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `addr_in`  in  32*Q_WIDTH  per-queue address; queue i occupies bits [32i+31:32i].
- `data_in`  in  CL_SIZE*Q_WIDTH  per-queue line data.
- `operation_in`  in  3*Q_WIDTH  per-queue opcode.
- `valid_in`  in  Q_WIDTH  per-queue head valid.
- `src_in`, `dest_in`  in  2*Q_WIDTH each  per-queue source and destination ids.
- `is_flush_in`  in  Q_WIDTH  per-queue flush flag.
- `ready_in`  in  1  downstream can accept `*_out` this cycle.
- `valid_out`  out  1  output register holds a request.
- `addr_out` 32, `data_out` CL_SIZE, `operation_out` 3, `src_out` 2, `dest_out` 2, `is_flush_out` 1  out  registered granted fields.
- `grant_idx_out`  out  $clog2(Q_WIDTH)  index of the queue that supplied the current output.
- `dealloc`  out  Q_WIDTH  one-hot pop pulse to the granted queue; combinational.

## Operation
- `load = ~valid_out | ready_in`: the output register is empty, or it is being drained this cycle.
- Eligible set: `E = valid_in`. If FLUSH_PRIO=1 and `|(valid_in & is_flush_in)`, then `E = valid_in & is_flush_in`.
- Grant: the first set bit of E, scanning upward from `rr_ptr` with wrap-around modulo Q_WIDTH. `grant` is one-hot, and zero when E is zero.
- `dealloc = load ? grant : 0`. The queue pops at the same edge that captures its entry.
- At a load edge with a nonzero grant, capture the granted queue's fields, set `valid_out=1`, set `grant_idx_out` to the index, and set `rr_ptr = (idx+1) mod Q_WIDTH`.
- At a load edge with a zero grant, set `valid_out=0` and clear all data outputs to 0, so `operation_out` is 0 whenever the register is invalid.
- When `load=0`, hold the outputs and `rr_ptr` and keep `dealloc=0`. The output must stay stable while `valid_out & ~ready_in`.
- `rr_ptr` advances only on an actual grant. Flush-priority grants also advance it.
- Reset: `valid_out`, all data outputs, `grant_idx_out` and `rr_ptr` are set to 0. `dealloc` is 0 during reset, regardless of `valid_in`.

## Timing
- Latency: 1 cycle from a selected `valid_in` to `valid_out`.
- Throughput: 1 request per cycle when `ready_in` is held high.
- Bubbles: none are inserted between back-to-back requests.
- Handshake: a transfer to downstream occurs on a cycle with `valid_out & ready_in`. A new grant can load on that same edge.
- The queues must present their next head (or deassert valid) on the cycle after `dealloc`. The arbiter does not filter a stale head.
- Asserting reset mid-transfer drops the held output; no `dealloc` is issued in that cycle.

## Structure
- Shared package `cache_pkg`: `CL_SIZE`, opcode width 3, src/dest width 2, and the opcode encodings.
- Sub-module `rr_pick #(WIDTH)`: inputs are the request vector and the pointer; output is the one-hot grant. It is implemented as a doubled-vector priority scan and is reused by the flush and normal paths.
- The top level holds the output register, `rr_ptr`, the eligible-set mux and the field mux.

## Test plan
- Reset, then `valid_in=6'b000000` for 5 cycles → `valid_out=0`, `operation_out=0`, `dealloc=0`.
- `valid_in=6'b111111` held, no flush, `ready_in=1` → grants 0,1,2,3,4,5,0 on consecutive cycles. Each cycle `dealloc` is one-hot and matches the next cycle's `grant_idx_out`.
- `valid_in=6'b100001`, `is_flush_in=6'b100000`, FLUSH_PRIO=1 → queue 5 is granted first; with FLUSH_PRIO=0, queue 0 is granted first.
- Output loaded from queue 2 with `addr=0x1000`, then `ready_in=0` for 4 cycles → `addr_out` holds 0x1000, `dealloc=0`, and `rr_ptr` is unchanged. When `ready_in` rises, the next grant loads on that edge.
- `valid_in` contains only queue 3 with `rr_ptr=4` → wrap-around grant of queue 3, after which `rr_ptr=4`.
- Assert `rst` while `valid_out=1` and `ready_in=0` → the next cycle has all outputs 0, and the following grant starts scanning from queue 0.
